free_list_mw: RTL and testbench
===============================

Name: free_list_mw

Overview:
- Parametrised multi-way physical-register free list for the rename stage; next generation of the 4-way, 64-PR free list.
- Circular buffer of free PR tags:
  - allocation pops up to WAY tags per cycle from alloc_ptr;
  - commit pushes up to WAY released tags per cycle at cmt_ptr;
  - branch flush rewinds alloc_ptr to a checkpointed position.
- Adds over the previous generation: generic width/depth/way, all-or-nothing grant, explicit free count, and sticky error flags.

Parameters:
- NUM_PREG, 64, total physical registers; PREG_W = clog2(NUM_PREG).
- NUM_AREG, 32, PRs mapped at reset (never in list initially).
- DEPTH, NUM_PREG-NUM_AREG, list entries; must be a power of 2; PTR_W = clog2(DEPTH).
- WAY, 4, allocate/commit lanes per cycle (1..8).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  blocks allocation only
- alloc_req  in  WAY  lane k needs a PR
- alloc_ok  out  1  grant; combinational
- pr_out  out  WAY*PREG_W  lane k tag at bits [k*PREG_W +: PREG_W]
- free_cnt  in  clog2(WAY+1)  number of valid free_pr_in lanes (packed from lane 0)
- free_pr_in  in  WAY*PREG_W  released tags from commit
- flush  in  1  restore alloc pointer
- flush_pos  in  PTR_W+1  checkpointed alloc position incl. wrap bit
- curr_pos  out  PTR_W+1  alloc_ptr, for checkpointing
- free_count  out  PTR_W+1  entries currently free (0..DEPTH)
- list_empty  out  1  free_count==0
- err_overflow  out  1  sticky; commit would exceed DEPTH
- err_underflow  out  1  sticky; flush_pos outside valid range

Behaviour:
- Pointers are PTR_W+1 bits (MSB = wrap bit); index uses low PTR_W bits.
- free_count = cmt_ptr - alloc_ptr, modulo 2^(PTR_W+1).
- Reset (rst=1 at posedge):
  - list[i] = NUM_AREG+i; alloc_ptr = 0; cmt_ptr = DEPTH (wrap bit set, low bits 0);
  - errors = 0; resulting free_count = DEPTH, list_empty = 0.
  - Reset overrides every other input, including mid-flush.
- Allocation, combinational same cycle:
  - n = popcount(alloc_req).
  - alloc_ok = !stall && !flush && (free_count >= n); n==0 gives alloc_ok=1 and consumes nothing.
  - Lane k gets list[alloc_ptr + popcount(alloc_req[k-1:0])]; non-requesting lanes output list[alloc_ptr] (don't-care).
  - pr_out is valid only when alloc_ok && alloc_req[k].
  - At posedge: if alloc_ok, alloc_ptr += n.
  - Partial grants never occur.
- Commit, at posedge:
  - Lanes 0..free_cnt-1 are written to list[cmt_ptr+j]; cmt_ptr += free_cnt.
  - Commit proceeds regardless of stall or flush.
  - If free_cnt > WAY, or the post-cycle count would exceed DEPTH: no write, cmt_ptr unchanged, err_overflow set.
- Flush, at posedge:
  - alloc_ptr = flush_pos; any allocation that cycle is ignored.
  - Valid when (cmt_ptr_next - flush_pos) mod 2^(PTR_W+1) <= DEPTH. Otherwise alloc_ptr is unchanged and err_underflow is set.
- Simultaneous commit + flush: both apply; free_count next = cmt_ptr_next - flush_pos.
- Wrap-around: tags at index DEPTH-1 and 0 are contiguous in one allocation; the wrap bit toggles.
- Empty: list_empty=1 and alloc_ok=0 for any n>0; a commit in the same cycle makes tags available next cycle (no bypass).
- Full (free_count==DEPTH): any free_cnt>0 sets err_overflow.
- Errors clear only on rst.
- Allocated pointer latency: new curr_pos visible the cycle after the grant.

Decomposition:
- Shared package rename_pkg holds:
  - NUM_PREG, NUM_AREG, WAY defaults;
  - PREG_W / PTR_W derivations;
  - a popcount function;
  - a preg_t typedef shared with the map table and ROB.
- One sub-module, free_list_prefix: WAY-bit request vector in, per-lane offsets plus total n out; purely combinational and reused by the map table.

Test Plan:
- Reset, then alloc_req=4'b1111 for 8 cycles, free_cnt=0:
  - cycle 1 pr_out = 32,33,34,35; curr_pos = 4 next cycle;
  - cycle 8 empties the list (list_empty=1, free_count=0);
  - cycle 9 alloc_ok=0.
- alloc_req=4'b1010 with free_count=32:
  - lane1=32, lane3=33, alloc_ok=1, curr_pos advances by 2.
- alloc_req=4'b0111 with free_count=2:
  - alloc_ok=0, curr_pos unchanged.
  - Same request with stall=1 and free_count=32: alloc_ok=0.
- Drain to empty, then commit free_cnt=4 with tags 5,9,12,20:
  - next cycle free_count=4, pr_out = 5,9,12,20 (index wraps 31->0).
- Allocate 12 (curr_pos=12), flush_pos=4 with same-cycle free_cnt=2:
  - next cycle curr_pos=4, free_count = (32+2) - 4 = 30.
- At full (free_count=32), free_cnt=1:
  - err_overflow=1, free_count stays 32.
- flush_pos beyond the valid range:
  - err_underflow=1, curr_pos unchanged.
- rst asserted mid-sequence:
  - all state reinitialised, errors cleared.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: default sizing, the physical tag type and
// a small popcount helper used by the free list and the map table.
package rename_pkg;
    localparam int DEF_NUM_PREG = 64;
    localparam int DEF_NUM_AREG = 32;
    localparam int DEF_WAY      = 4;
    localparam int DEF_PREG_W   = $clog2(DEF_NUM_PREG);
    localparam int DEF_PTR_W    = $clog2(DEF_NUM_PREG - DEF_NUM_AREG);

    typedef logic [DEF_PREG_W-1:0] preg_t;

    // Handles up to 8 lanes, the widest rename width supported.
    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/free_list_prefix.sv
// Exclusive prefix count of a request vector: lane k gets the number of
// requesting lanes below it, plus the overall request total.
module free_list_prefix
    import rename_pkg::*;
#(
    parameter  int WAY   = DEF_WAY,
    localparam int OFF_W = $clog2(WAY + 1)
) (
    input  logic [WAY-1:0]       req,
    output logic [WAY*OFF_W-1:0] offset,
    output logic [OFF_W-1:0]     total
);
    for (genvar gi = 0; gi < WAY; gi++) begin : g_lane
        localparam logic [WAY-1:0] LOWER_MASK = WAY'((1 << gi) - 1);
        assign offset[gi*OFF_W +: OFF_W] = OFF_W'(popcount(8'(req & LOWER_MASK)));
    end

    assign total = OFF_W'(popcount(8'(req)));
endmodule

// File: rtl/free_list_mw.sv
// Multi-way circular free list of physical register tags: all-or-nothing
// allocation, multi-lane commit push, checkpoint flush and sticky error flags.
module free_list_mw
    import rename_pkg::*;
#(
    parameter  int NUM_PREG = DEF_NUM_PREG,
    parameter  int NUM_AREG = DEF_NUM_AREG,
    parameter  int DEPTH    = NUM_PREG - NUM_AREG,
    parameter  int WAY      = DEF_WAY,
    localparam int PREG_W   = $clog2(NUM_PREG),
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(WAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [WAY-1:0]        alloc_req,
    output logic                  alloc_ok,
    output logic [WAY*PREG_W-1:0] pr_out,
    input  logic [CNT_W-1:0]      free_cnt,
    input  logic [WAY*PREG_W-1:0] free_pr_in,
    input  logic                  flush,
    input  logic [PTR_W:0]        flush_pos,
    output logic [PTR_W:0]        curr_pos,
    output logic [PTR_W:0]        free_count,
    output logic                  list_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);
    // Wide enough that count + commit lanes never wraps before the range check.
    localparam int EXT_W = PTR_W + CNT_W + 1;

    logic [PTR_W:0]      alloc_q, alloc_d;
    logic [PTR_W:0]      cmt_q, cmt_d;
    logic [PREG_W-1:0]   list_q [DEPTH];
    logic [PREG_W-1:0]   list_d [DEPTH];
    logic                err_ov_q, err_ov_d;
    logic                err_un_q, err_un_d;
    logic [WAY*CNT_W-1:0] lane_off;
    logic [CNT_W-1:0]    n_req;
    logic [EXT_W-1:0]    n_grant;
    logic [EXT_W-1:0]    post_cnt;
    logic                commit_ok;
    logic [PTR_W:0]      flush_span;

    free_list_prefix #(.WAY(WAY)) u_prefix (
        .req    (alloc_req),
        .offset (lane_off),
        .total  (n_req)
    );

    assign free_count    = cmt_q - alloc_q;
    assign list_empty    = (free_count == '0);
    assign alloc_ok      = !stall && !flush && (free_count >= (PTR_W+1)'(n_req));
    assign curr_pos      = alloc_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

    // Idle lanes read the head entry so their mux select stays trivial.
    for (genvar gi = 0; gi < WAY; gi++) begin : g_rd
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx = alloc_q[PTR_W-1:0] +
                        (alloc_req[gi] ? PTR_W'(lane_off[gi*CNT_W +: CNT_W]) : '0);
        assign pr_out[gi*PREG_W +: PREG_W] = list_q[rd_idx];
    end

    always_comb begin
        list_d    = list_q;
        cmt_d     = cmt_q;
        err_ov_d  = err_ov_q;
        err_un_d  = err_un_q;
        n_grant   = alloc_ok ? EXT_W'(n_req) : '0;
        post_cnt  = EXT_W'(free_count) + EXT_W'(free_cnt) - n_grant;
        commit_ok = (free_cnt <= CNT_W'(WAY)) && (post_cnt <= EXT_W'(DEPTH));

        if (commit_ok) begin
            for (int j = 0; j < WAY; j++) begin
                if (CNT_W'(j) < free_cnt) begin
                    list_d[cmt_q[PTR_W-1:0] + PTR_W'(j)] = free_pr_in[j*PREG_W +: PREG_W];
                end
            end
            cmt_d = cmt_q + (PTR_W+1)'(free_cnt);
        end else begin
            err_ov_d = 1'b1;
        end

        // The checkpoint must lie within DEPTH entries behind the new commit point.
        alloc_d    = alloc_q + (PTR_W+1)'(n_grant);
        flush_span = cmt_d - flush_pos;
        if (flush) begin
            if (flush_span <= (PTR_W+1)'(DEPTH)) begin
                alloc_d = flush_pos;
            end else begin
                err_un_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                list_q[i] <= PREG_W'(NUM_AREG + i);
            end
            alloc_q  <= '0;
            cmt_q    <= (PTR_W+1)'(DEPTH);
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            list_q   <= list_d;
            alloc_q  <= alloc_d;
            cmt_q    <= cmt_d;
            err_ov_q <= err_ov_d;
            err_un_q <= err_un_d;
        end
    end
endmodule

// File: tb/tb_free_list_mw.sv
// Bench for free_list_mw: directed table, hand-written corner sequences and
// randomized traffic checked against a pointer-arithmetic reference model.
module tb_free_list_mw;
    localparam int WAY      = 4;
    localparam int PREG_W   = 6;
    localparam int DEPTH    = 32;
    localparam int NUM_AREG = 32;
    localparam int PMOD     = 2 * DEPTH;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [3:0]  alloc_req;
    logic        alloc_ok;
    logic [23:0] pr_out, free_pr_in;
    logic [2:0]  free_cnt;
    logic [5:0]  flush_pos, curr_pos, free_count;
    logic        list_empty, err_overflow, err_underflow;

    free_list_mw dut (
        .clk(clk), .rst(rst), .stall(stall), .alloc_req(alloc_req),
        .alloc_ok(alloc_ok), .pr_out(pr_out), .free_cnt(free_cnt),
        .free_pr_in(free_pr_in), .flush(flush), .flush_pos(flush_pos),
        .curr_pos(curr_pos), .free_count(free_count), .list_empty(list_empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int m_mem [DEPTH];
    int m_alloc, m_cmt;
    bit m_eov, m_eun;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        stall;
        logic [3:0]  req;
        logic [2:0]  fcnt;
        logic [23:0] tags;
        logic        flush;
        logic [5:0]  fpos;
        logic        exp_ok;
        int          exp_curr;
        int          exp_fc;
        logic        exp_eov;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pc(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int m_fc();
        return (m_cmt - m_alloc + PMOD) % PMOD;
    endfunction

    function automatic bit m_ok();
        return !stall && !flush && (m_fc() >= pc(alloc_req));
    endfunction

    task automatic check_model();
        bit ok = m_ok();
        int off = 0;
        chk("alloc_ok", alloc_ok, int'(ok));
        if (ok) begin
            for (int k = 0; k < WAY; k++) begin
                if (alloc_req[k]) begin
                    chk($sformatf("pr_out[%0d]", k), pr_out[k*PREG_W +: PREG_W],
                        m_mem[(m_alloc + off) % DEPTH]);
                    off++;
                end
            end
        end
        chk("free_count", free_count, m_fc());
        chk("curr_pos", curr_pos, m_alloc);
        chk("list_empty", list_empty, int'(m_fc() == 0));
        chk("err_overflow", err_overflow, int'(m_eov));
        chk("err_underflow", err_underflow, int'(m_eun));
    endtask

    task automatic model_update();
        int g, fc, fcnt;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = NUM_AREG + i;
            m_alloc = 0;
            m_cmt   = DEPTH;
            m_eov   = 0;
            m_eun   = 0;
            return;
        end
        g    = m_ok() ? pc(alloc_req) : 0;
        fc   = m_fc();
        fcnt = int'(free_cnt);
        if (fcnt > WAY || fc - g + fcnt > DEPTH) begin
            m_eov = 1;
        end else begin
            for (int j = 0; j < fcnt; j++)
                m_mem[(m_cmt + j) % DEPTH] = int'(free_pr_in[j*PREG_W +: PREG_W]);
            m_cmt = (m_cmt + fcnt) % PMOD;
        end
        m_alloc = (m_alloc + g) % PMOD;
        if (flush) begin
            if ((m_cmt - int'(flush_pos) + PMOD) % PMOD <= DEPTH) m_alloc = int'(flush_pos);
            else m_eun = 1;
        end
    endtask

    task automatic set_idle();
        rst = 0; stall = 0; alloc_req = '0; free_cnt = '0;
        free_pr_in = '0; flush = 0; flush_pos = '0;
    endtask

    task automatic pre_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        post_edge();
        rst = 0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'b1010, 3'd0, 24'd0, 1'b0, 6'd0, 1'b1, 2, 30, 1'b0};
        tbl[1] = '{1'b1, 4'b0111, 3'd0, 24'd0, 1'b0, 6'd0, 1'b0, 2, 30, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 3'd0, 24'd0, 1'b1, 6'd0, 1'b0, 0, 32, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 3'd1, 24'd7, 1'b0, 6'd0, 1'b1, 0, 32, 1'b1};
        tbl[4] = '{1'b0, 4'b1111, 3'd0, 24'd0, 1'b0, 6'd0, 1'b1, 4, 28, 1'b1};
        tbl[5] = '{1'b0, 4'b0001, 3'd2, {12'd0, 6'd41, 6'd40}, 1'b0, 6'd0, 1'b1, 5, 29, 1'b1};

        do_reset();
        chk("rst_free_count", free_count, 32);
        chk("rst_curr_pos", curr_pos, 0);
        chk("rst_list_empty", list_empty, 0);
        chk("rst_err_ov", err_overflow, 0);
        chk("rst_err_un", err_underflow, 0);

        // Directed table from reset.
        for (int i = 0; i < 6; i++) begin
            stall = tbl[i].stall; alloc_req = tbl[i].req; free_cnt = tbl[i].fcnt;
            free_pr_in = tbl[i].tags; flush = tbl[i].flush; flush_pos = tbl[i].fpos;
            pre_edge();
            chk($sformatf("tbl%0d_ok", i), alloc_ok, int'(tbl[i].exp_ok));
            if (i == 0) begin
                chk("tbl0_lane1", pr_out[6 +: 6], 32);
                chk("tbl0_lane3", pr_out[18 +: 6], 33);
            end
            if (i == 5) chk("tbl5_lane0", pr_out[0 +: 6], 36);
            post_edge();
            chk($sformatf("tbl%0d_curr", i), curr_pos, tbl[i].exp_curr);
            chk($sformatf("tbl%0d_fc", i), free_count, tbl[i].exp_fc);
            chk($sformatf("tbl%0d_eov", i), err_overflow, int'(tbl[i].exp_eov));
        end

        // Drain the whole list four tags at a time.
        do_reset();
        alloc_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            pre_edge();
            if (i == 0) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("drain_lane%0d", k), pr_out[k*6 +: 6], 32 + k);
            end
            post_edge();
            if (i == 0) chk("drain_curr", curr_pos, 4);
        end
        chk("drained_empty", list_empty, 1);
        chk("drained_fc", free_count, 0);

        // Commit into an empty list while still requesting: no bypass.
        free_cnt = 3'd4;
        free_pr_in = {6'd20, 6'd12, 6'd9, 6'd5};
        pre_edge();
        chk("empty_ok", alloc_ok, 0);
        post_edge();
        chk("refill_fc", free_count, 4);
        free_cnt = '0;
        pre_edge();
        chk("refill_ok", alloc_ok, 1);
        chk("refill_lane0", pr_out[0 +: 6], 5);
        chk("refill_lane1", pr_out[6 +: 6], 9);
        chk("refill_lane2", pr_out[12 +: 6], 12);
        chk("refill_lane3", pr_out[18 +: 6], 20);
        post_edge();

        // Flush with a same-cycle commit, then an out-of-range flush.
        do_reset();
        alloc_req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            pre_edge();
            post_edge();
        end
        chk("pre_flush_curr", curr_pos, 12);
        alloc_req = '0; flush = 1; flush_pos = 6'd4;
        free_cnt = 3'd2; free_pr_in = {12'd0, 6'd3, 6'd2};
        pre_edge();
        post_edge();
        chk("flush_curr", curr_pos, 4);
        chk("flush_fc", free_count, 30);
        free_cnt = '0; flush_pos = 6'd1;
        pre_edge();
        post_edge();
        chk("bad_flush_curr", curr_pos, 4);
        chk("bad_flush_eun", err_underflow, 1);

        // Reset wins over a simultaneous flush, commit and allocation.
        rst = 1; flush_pos = 6'd9; free_cnt = 3'd3; alloc_req = 4'b1111;
        post_edge();
        chk("midrst_fc", free_count, 32);
        chk("midrst_curr", curr_pos, 0);
        chk("midrst_eun", err_underflow, 0);
        chk("midrst_eov", err_overflow, 0);
        set_idle();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst       = ($urandom_range(0, 199) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            alloc_req = 4'($urandom);
            r = $urandom_range(0, 99);
            if (r < 3) free_cnt = 3'd5;
            else if (r < 8) free_cnt = 3'($urandom_range(0, 4));
            else free_cnt = 3'($urandom_range(0, (DEPTH - m_fc()) < 4 ? (DEPTH - m_fc()) : 4));
            free_pr_in = 24'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            flush_pos  = 6'((m_cmt - $urandom_range(0, DEPTH + 1) + PMOD) % PMOD);
            pre_edge();
            post_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
